// File: rtl/cpu_mei_controller_if.sv
// Register bus between the CPU data port and the external-interrupt controller.
interface cpu_mei_controller_if #(
    parameter int unsigned XLEN = 32
);
    logic [7:0]      reg_addr;
    logic [XLEN-1:0] reg_wdata;
    logic [3:0]      reg_wenable;
    logic            reg_rden;
    logic [XLEN-1:0] reg_rdata;

    modport master (
        output reg_addr, reg_wdata, reg_wenable, reg_rden,
        input  reg_rdata
    );

    modport slave (
        input  reg_addr, reg_wdata, reg_wenable, reg_rden,
        output reg_rdata
    );
endinterface

// File: rtl/cpu_mei_controller.sv
// External-interrupt controller: synchronises level sources, latches them into
// pending bits, selects the highest-priority eligible source above the threshold,
// and supports claim (read) / complete (write) through register offset 0x0C.
module cpu_mei_controller #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned MEI_PORTS = 4,
    parameter int unsigned PRIO_BITS = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [MEI_PORTS-1:0] irq_src,
    cpu_mei_controller_if.slave  bus,
    output logic                 mei_pending
);

    logic [MEI_PORTS-1:0] sync1_q, sync2_q;
    logic [MEI_PORTS-1:0] pending_q, pending_d;
    logic [MEI_PORTS-1:0] in_service_q, in_service_d;
    logic [MEI_PORTS-1:0] enable_q, enable_d;
    logic [PRIO_BITS-1:0] thresh_q, thresh_d;
    logic [PRIO_BITS-1:0] prio_q [MEI_PORTS];
    logic [PRIO_BITS-1:0] prio_d [MEI_PORTS];
    logic                 mei_pending_q;

    logic [MEI_PORTS-1:0] eligible;
    logic [4:0]           win_id;
    logic [PRIO_BITS-1:0] win_prio;
    logic [5:0]           word;
    logic                 claim_fire, complete_fire;
    logic [4:0]           complete_id;
    logic [MEI_PORTS-1:0] claim_mask, complete_mask;
    logic                 unused_bits;

    assign word        = bus.reg_addr[7:2];
    assign complete_id = bus.reg_wdata[4:0];
    assign unused_bits = ^{bus.reg_addr[1:0], bus.reg_wdata};
    assign mei_pending = mei_pending_q;

    // Eligibility and winner: strict '>' keeps the lowest ID on priority ties.
    always_comb begin
        eligible = '0;
        win_id   = '0;
        win_prio = '0;
        for (int i = 0; i < int'(MEI_PORTS); i++) begin
            eligible[i] = pending_q[i] & enable_q[i] & (prio_q[i] > thresh_q);
            if (eligible[i] && (win_id == 5'd0 || prio_q[i] > win_prio)) begin
                win_id   = 5'(i + 1);
                win_prio = prio_q[i];
            end
        end
    end

    // Claim / complete decode; a claim returning ID 0 has no side effect.
    always_comb begin
        claim_fire    = bus.reg_rden && (word == 6'd3) && (win_id != 5'd0);
        complete_fire = bus.reg_wenable[0] && (word == 6'd3);
        claim_mask    = '0;
        complete_mask = '0;
        for (int i = 0; i < int'(MEI_PORTS); i++) begin
            claim_mask[i]    = claim_fire && (win_id == 5'(i + 1));
            complete_mask[i] = complete_fire && (complete_id == 5'(i + 1));
        end
    end

    // Next state: gateway set is blocked by in_service; a same-edge claim wins over it.
    always_comb begin
        pending_d    = (pending_q | (sync2_q & ~in_service_q)) & ~claim_mask;
        in_service_d = (in_service_q & ~complete_mask) | claim_mask;
        enable_d     = enable_q;
        thresh_d     = thresh_q;
        prio_d       = prio_q;
        if (word == 6'd1) begin
            for (int i = 0; i < int'(MEI_PORTS); i++) begin
                if (bus.reg_wenable[i / 8]) enable_d[i] = bus.reg_wdata[i];
            end
        end
        if (word == 6'd2 && bus.reg_wenable[0]) thresh_d = bus.reg_wdata[PRIO_BITS-1:0];
        for (int i = 0; i < int'(MEI_PORTS); i++) begin
            if (word == 6'(i + 4) && bus.reg_wenable[0]) begin
                prio_d[i] = bus.reg_wdata[PRIO_BITS-1:0];
            end
        end
    end

    // Combinational register read; unmapped offsets return 0.
    always_comb begin
        bus.reg_rdata = '0;
        case (word)
            6'd0: bus.reg_rdata[MEI_PORTS-1:0] = pending_q;
            6'd1: bus.reg_rdata[MEI_PORTS-1:0] = enable_q;
            6'd2: bus.reg_rdata[PRIO_BITS-1:0] = thresh_q;
            6'd3: bus.reg_rdata[4:0]           = win_id;
            default: begin
                for (int i = 0; i < int'(MEI_PORTS); i++) begin
                    if (word == 6'(i + 4)) bus.reg_rdata[PRIO_BITS-1:0] = prio_q[i];
                end
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            pending_q     <= '0;
            in_service_q  <= '0;
            enable_q      <= '0;
            thresh_q      <= '0;
            mei_pending_q <= 1'b0;
            for (int i = 0; i < int'(MEI_PORTS); i++) prio_q[i] <= '0;
        end else begin
            sync1_q       <= irq_src;
            sync2_q       <= sync1_q;
            pending_q     <= pending_d;
            in_service_q  <= in_service_d;
            enable_q      <= enable_d;
            thresh_q      <= thresh_d;
            mei_pending_q <= |eligible;
            prio_q        <= prio_d;
        end
    end

endmodule

// File: tb/tb_cpu_mei_controller.sv
// Directed bench for cpu_mei_controller: register table plus claim/complete sequences.
module tb_cpu_mei_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] irq_src = '0;
    logic       mei_pending;

    int vec_cnt  = 0;
    int fail_cnt = 0;

    cpu_mei_controller_if #(.XLEN(32)) bus ();

    cpu_mei_controller #(
        .XLEN(32),
        .MEI_PORTS(4),
        .PRIO_BITS(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .irq_src(irq_src),
        .bus(bus),
        .mei_pending(mei_pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  wen;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [15];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] we);
        bus.reg_addr    = a;
        bus.reg_wdata   = d;
        bus.reg_wenable = we;
        step();
        bus.reg_wenable = '0;
        bus.reg_wdata   = '0;
    endtask

    task automatic rd_chk(input logic [7:0] a, input logic [31:0] exp, input string name);
        bus.reg_addr = a;
        bus.reg_rden = 1'b0;
        #1;
        chk(name, bus.reg_rdata, exp);
    endtask

    task automatic claim(input logic [31:0] exp, input string name);
        bus.reg_addr = 8'h0C;
        bus.reg_rden = 1'b1;
        #1;
        chk(name, bus.reg_rdata, exp);
        step();
        bus.reg_rden = 1'b0;
    endtask

    task automatic do_reset();
        irq_src         = '0;
        bus.reg_wenable = '0;
        bus.reg_rden    = 1'b0;
        rst_n           = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        bus.reg_addr    = '0;
        bus.reg_wdata   = '0;
        bus.reg_wenable = '0;
        bus.reg_rden    = 1'b0;

        tbl[0]  = '{8'h04, 32'hFFFF_FFFF, 4'hF, 32'h0000_000F};
        tbl[1]  = '{8'h04, 32'h0000_0000, 4'h0, 32'h0000_000F};
        tbl[2]  = '{8'h04, 32'h0000_0000, 4'h2, 32'h0000_000F};
        tbl[3]  = '{8'h04, 32'h0000_0000, 4'h1, 32'h0000_0000};
        tbl[4]  = '{8'h08, 32'hFFFF_FFFF, 4'h1, 32'h0000_0007};
        tbl[5]  = '{8'h08, 32'h0000_0000, 4'hE, 32'h0000_0007};
        tbl[6]  = '{8'h08, 32'h0000_0000, 4'h1, 32'h0000_0000};
        tbl[7]  = '{8'h10, 32'h0000_0005, 4'h1, 32'h0000_0005};
        tbl[8]  = '{8'h1C, 32'h0000_00FE, 4'h1, 32'h0000_0006};
        tbl[9]  = '{8'h1D, 32'h0000_0002, 4'h1, 32'h0000_0002};
        tbl[10] = '{8'h20, 32'h0000_0007, 4'h1, 32'h0000_0000};
        tbl[11] = '{8'h00, 32'h0000_000F, 4'hF, 32'h0000_0000};
        tbl[12] = '{8'hFC, 32'h0000_0001, 4'hF, 32'h0000_0000};
        tbl[13] = '{8'h0C, 32'h0000_0000, 4'h0, 32'h0000_0000};
        tbl[14] = '{8'h14, 32'h0000_0003, 4'h1, 32'h0000_0003};

        // Reset state
        do_reset();
        chk("rst_mei", {31'd0, mei_pending}, 32'd0);
        rd_chk(8'h00, 32'h0, "rst_pending");
        rd_chk(8'h04, 32'h0, "rst_enable");
        rd_chk(8'h08, 32'h0, "rst_thresh");
        rd_chk(8'h10, 32'h0, "rst_prio0");

        // Register write / read-back table
        for (int i = 0; i < 15; i++) begin
            if (tbl[i].wen != 4'h0) wr(tbl[i].addr, tbl[i].wdata, tbl[i].wen);
            rd_chk(tbl[i].addr, tbl[i].exp, $sformatf("tbl[%0d]", i));
        end

        // 1: synchroniser + gateway + output latency
        do_reset();
        wr(8'h10, 32'd1, 4'h1);
        wr(8'h04, 32'h1, 4'h1);
        irq_src = 4'b0001;
        step();
        chk("lat_k0", {31'd0, mei_pending}, 32'd0);
        step();
        chk("lat_k1", {31'd0, mei_pending}, 32'd0);
        rd_chk(8'h00, 32'h0, "lat_pend_k1");
        step();
        chk("lat_k2", {31'd0, mei_pending}, 32'd0);
        rd_chk(8'h00, 32'h1, "lat_pend_k2");
        step();
        chk("lat_k3", {31'd0, mei_pending}, 32'd1);

        // 2: priority order, ties to lowest ID, claim + complete in one cycle
        do_reset();
        wr(8'h10, 32'd1, 4'h1);
        wr(8'h14, 32'd3, 4'h1);
        wr(8'h18, 32'd3, 4'h1);
        wr(8'h1C, 32'd2, 4'h1);
        wr(8'h04, 32'hF, 4'h1);
        irq_src = 4'hF;
        step(); step(); step();
        irq_src = 4'h0;
        step(); step(); step();
        rd_chk(8'h00, 32'hF, "prio_pend_all");
        chk("prio_mei", {31'd0, mei_pending}, 32'd1);
        claim(32'd2, "claim_2");
        wr(8'h0C, 32'd2, 4'h1);
        claim(32'd3, "claim_3");
        bus.reg_addr    = 8'h0C;
        bus.reg_rden    = 1'b1;
        bus.reg_wdata   = 32'd3;
        bus.reg_wenable = 4'h1;
        #1;
        chk("claim_4_cmpl_3", bus.reg_rdata, 32'd4);
        step();
        bus.reg_rden    = 1'b0;
        bus.reg_wenable = '0;
        claim(32'd1, "claim_1");
        claim(32'd0, "claim_none");
        step();
        chk("prio_mei_done", {31'd0, mei_pending}, 32'd0);
        rd_chk(8'h00, 32'h0, "prio_pend_done");

        // 3: held source does not re-pend until completed
        do_reset();
        wr(8'h10, 32'd1, 4'h1);
        wr(8'h04, 32'h1, 4'h1);
        irq_src = 4'b0001;
        step(); step(); step();
        claim(32'd1, "hold_claim_1");
        rd_chk(8'h00, 32'h0, "hold_pend_clr");
        step(); step(); step();
        rd_chk(8'h00, 32'h0, "hold_no_repend");
        chk("hold_mei_0", {31'd0, mei_pending}, 32'd0);
        wr(8'h0C, 32'd1, 4'h1);
        rd_chk(8'h00, 32'h0, "hold_cmpl_edge");
        step();
        rd_chk(8'h00, 32'h1, "hold_repend");
        step();
        chk("hold_mei_1", {31'd0, mei_pending}, 32'd1);

        // 4: threshold gating (prio must exceed thresh)
        do_reset();
        wr(8'h10, 32'd3, 4'h1);
        wr(8'h04, 32'h1, 4'h1);
        wr(8'h08, 32'd3, 4'h1);
        irq_src = 4'b0001;
        step(); step(); step(); step();
        chk("thr_mei_0", {31'd0, mei_pending}, 32'd0);
        rd_chk(8'h00, 32'h1, "thr_pend");
        claim(32'd0, "thr_claim_0");
        rd_chk(8'h00, 32'h1, "thr_pend_kept");
        wr(8'h08, 32'd2, 4'h1);
        chk("thr_mei_wedge", {31'd0, mei_pending}, 32'd0);
        step();
        chk("thr_mei_1", {31'd0, mei_pending}, 32'd1);

        // 5: ignored completes; empty claim has no side effect
        claim(32'd1, "cmpl_claim_1");
        wr(8'h0C, 32'd0, 4'h1);
        wr(8'h0C, 32'd7, 4'h1);
        wr(8'h0C, 32'd2, 4'h1);
        step(); step();
        rd_chk(8'h00, 32'h0, "cmpl_ignored");
        claim(32'd0, "cmpl_claim_0");
        rd_chk(8'h00, 32'h0, "cmpl_still_0");
        wr(8'h0C, 32'd1, 4'h1);
        step();
        rd_chk(8'h00, 32'h1, "cmpl_real");

        // 6: reset mid-service
        do_reset();
        wr(8'h14, 32'd2, 4'h1);
        wr(8'h18, 32'd1, 4'h1);
        wr(8'h04, 32'hF, 4'h1);
        irq_src = 4'b0110;
        step(); step(); step();
        claim(32'd2, "rst_claim_2");
        rd_chk(8'h00, 32'h4, "rst_pre_pend");
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rst_mid_mei", {31'd0, mei_pending}, 32'd0);
        rd_chk(8'h00, 32'h0, "rst_mid_pend");
        rd_chk(8'h04, 32'h0, "rst_mid_en");
        rd_chk(8'h14, 32'h0, "rst_mid_prio1");
        rd_chk(8'h0C, 32'h0, "rst_mid_claim");
        wr(8'h14, 32'd1, 4'h1);
        wr(8'h04, 32'h6, 4'h1);
        step(); step(); step(); step();
        rd_chk(8'h00, 32'h6, "rst_no_service");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, fail_cnt);
        $finish;
    end

endmodule
